// File: rtl/serial_bus_arbiter.sv
// Two-master round-robin arbiter for the serial system bus.
// Owns the shared-bus mux select and handles one outstanding split
// transaction: it parks the owner, lends the bus to the other master,
// then returns the bus to the parked master with split_grant raised.
module serial_bus_arbiter #(
    parameter bit          SPLIT_EN = 1'b1,
    parameter int unsigned MAX_HOLD = 64
) (
    input  logic clk,
    input  logic rstn,
    input  logic breq1,
    input  logic breq2,
    output logic bgrant1,
    output logic bgrant2,
    output logic msel,
    input  logic ssplit,
    output logic split_grant,
    output logic split_owner,
    output logic split_pend
);

    // Counter just wide enough to reach MAX_HOLD; kept at one bit when the limit is off.
    localparam int unsigned              CNT_W      = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [CNT_W-1:0]         HOLD_LIMIT = CNT_W'(MAX_HOLD);

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_OWN        = 2'd1,
        S_SPLIT_LEND = 2'd2,
        S_SPLIT_RET  = 2'd3
    } state_e;

    state_e           state_q;
    logic             bgrant1_q;
    logic             bgrant2_q;
    logic             msel_q;
    logic             split_grant_q;
    logic             split_owner_q;
    logic             split_pend_q;
    logic             rr_ptr_q;       // 0 = master 1 wins the next tie, 1 = master 2
    logic [CNT_W-1:0] hold_cnt_q;
    logic [CNT_W-1:0] hold_cnt_d;
    logic             breq1_q;
    logic             breq2_q;
    logic             ssplit_q;

    // Requests seen from the point of view of the current owner and of a parked split.
    logic owner_req;
    logic other_req;
    logic lent_req;
    logic parked_req;
    logic parked_req_q;
    logic parked_fall;
    logic ssplit_rise;
    logic hold_limit_hit;

    assign owner_req    = msel_q ? breq2 : breq1;
    assign other_req    = msel_q ? breq1 : breq2;
    assign lent_req     = split_owner_q ? breq1 : breq2;
    assign parked_req   = split_owner_q ? breq2 : breq1;
    assign parked_req_q = split_owner_q ? breq2_q : breq1_q;

    // Abort only on a falling edge, so an owner that dropped breq in the very
    // cycle the split arrived is still treated as parked rather than aborted.
    assign parked_fall    = parked_req_q && !parked_req;
    assign ssplit_rise    = SPLIT_EN && ssplit && !ssplit_q;
    assign hold_limit_hit = (MAX_HOLD != 0) && (hold_cnt_q == HOLD_LIMIT);

    // Saturating count of OWN cycles during which the other master is waiting.
    always_comb begin
        // NOTE: default first so every path assigns hold_cnt_d; otherwise a latch is inferred.
        hold_cnt_d = hold_cnt_q;
        if ((MAX_HOLD != 0) && other_req && !hold_limit_hit) begin
            hold_cnt_d = hold_cnt_q + CNT_W'(1);
        end
    end

    // Arbitration FSM; every output is a register updated here.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= S_IDLE;
            bgrant1_q     <= 1'b0;
            bgrant2_q     <= 1'b0;
            msel_q        <= 1'b0;
            split_grant_q <= 1'b0;
            split_owner_q <= 1'b0;
            split_pend_q  <= 1'b0;
            rr_ptr_q      <= 1'b0;
            hold_cnt_q    <= '0;
            breq1_q       <= 1'b0;
            breq2_q       <= 1'b0;
            ssplit_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register sees the pre-edge values of the others.
            breq1_q  <= breq1;
            breq2_q  <= breq2;
            ssplit_q <= ssplit;

            case (state_q)
                S_IDLE: begin
                    hold_cnt_q    <= '0;
                    split_grant_q <= 1'b0;
                    if (!split_pend_q) begin
                        if (breq1 && breq2) begin
                            // Tie: the pointer decides, then moves to the loser.
                            msel_q    <= rr_ptr_q;
                            bgrant1_q <= !rr_ptr_q;
                            bgrant2_q <= rr_ptr_q;
                            rr_ptr_q  <= !rr_ptr_q;
                            state_q   <= S_OWN;
                        end else if (breq1) begin
                            msel_q    <= 1'b0;
                            bgrant1_q <= 1'b1;
                            bgrant2_q <= 1'b0;
                            state_q   <= S_OWN;
                        end else if (breq2) begin
                            msel_q    <= 1'b1;
                            bgrant1_q <= 1'b0;
                            bgrant2_q <= 1'b1;
                            state_q   <= S_OWN;
                        end
                    end
                end

                S_OWN: begin
                    if (ssplit_rise) begin
                        // Split wins over a simultaneous release: park the owner.
                        split_owner_q <= msel_q;
                        split_pend_q  <= 1'b1;
                        hold_cnt_q    <= '0;
                        if (other_req) begin
                            msel_q    <= !msel_q;
                            bgrant1_q <= msel_q;
                            bgrant2_q <= !msel_q;
                            state_q   <= S_SPLIT_LEND;
                        end else begin
                            // Nobody to lend to: go straight to returning the bus.
                            split_grant_q <= 1'b1;
                            bgrant1_q     <= !msel_q;
                            bgrant2_q     <= msel_q;
                            state_q       <= S_SPLIT_RET;
                        end
                    end else if (!owner_req) begin
                        bgrant1_q  <= 1'b0;
                        bgrant2_q  <= 1'b0;
                        hold_cnt_q <= '0;
                        state_q    <= S_IDLE;
                        // An owner that held the bus too long loses the next tie.
                        if (hold_limit_hit) begin
                            rr_ptr_q <= !msel_q;
                        end
                    end else begin
                        hold_cnt_q <= hold_cnt_d;
                    end
                end

                S_SPLIT_LEND: begin
                    // A second split from the lent master is not tracked.
                    if (parked_fall) begin
                        bgrant1_q     <= 1'b0;
                        bgrant2_q     <= 1'b0;
                        split_grant_q <= 1'b0;
                        split_pend_q  <= 1'b0;
                        state_q       <= S_IDLE;
                    end else if (!lent_req) begin
                        msel_q        <= split_owner_q;
                        bgrant1_q     <= !split_owner_q;
                        bgrant2_q     <= split_owner_q;
                        split_grant_q <= 1'b1;
                        state_q       <= S_SPLIT_RET;
                    end
                end

                S_SPLIT_RET: begin
                    if (parked_fall) begin
                        bgrant1_q     <= 1'b0;
                        bgrant2_q     <= 1'b0;
                        split_grant_q <= 1'b0;
                        split_pend_q  <= 1'b0;
                        state_q       <= S_IDLE;
                    end else if (!ssplit) begin
                        // Slave has left SPLIT; the owner now finishes its read.
                        split_grant_q <= 1'b0;
                        split_pend_q  <= 1'b0;
                        hold_cnt_q    <= '0;
                        state_q       <= S_OWN;
                    end
                end

                default: begin
                    bgrant1_q     <= 1'b0;
                    bgrant2_q     <= 1'b0;
                    split_grant_q <= 1'b0;
                    split_pend_q  <= 1'b0;
                    state_q       <= S_IDLE;
                end
            endcase
        end
    end

    assign bgrant1     = bgrant1_q;
    assign bgrant2     = bgrant2_q;
    assign msel        = msel_q;
    assign split_grant = split_grant_q;
    assign split_owner = split_owner_q;
    assign split_pend  = split_pend_q;

    // The two grants are mutually exclusive in every cycle.
    a_grant_onehot : assert property (@(posedge clk) disable iff (!rstn) !(bgrant1_q && bgrant2_q));

endmodule
